// File: rtl/stepper_pkg.sv
// Shared types and default widths for the stepper motion sequencer.
//   state_t : sequencer FSM states
//   cmd_t   : one move command as presented by the register slave
package stepper_pkg;

  localparam int unsigned POS_W_DEF    = 32;
  localparam int unsigned PERIOD_W_DEF = 24;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DIR_SETUP = 3'd1,
    STEP_HIGH = 3'd2,
    STEP_LOW  = 3'd3,
    DONE      = 3'd4
  } state_t;

  typedef struct packed {
    logic [POS_W_DEF-1:0]    steps;
    logic                    dir;
    logic [PERIOD_W_DEF-1:0] start_period;
    logic [PERIOD_W_DEF-1:0] min_period;
    logic [PERIOD_W_DEF-1:0] accel;
  } cmd_t;

endpackage

// File: rtl/stepper_motion_sequencer_if.sv
// Command/status bundle between the register slave (master modport) and the
// sequencer (slave modport).
//   cmd_valid/cmd_ready : move command handshake
//   cmd_*               : step count, direction and ramp settings
//   busy/done           : move in progress / one-cycle end-of-move pulse
//   position            : signed absolute position
//   steps_remaining     : steps not yet issued
interface stepper_motion_sequencer_if #(
  parameter int unsigned POS_W    = stepper_pkg::POS_W_DEF,
  parameter int unsigned PERIOD_W = stepper_pkg::PERIOD_W_DEF
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [POS_W-1:0]    cmd_steps;
  logic                cmd_dir;
  logic [PERIOD_W-1:0] cmd_start_period;
  logic [PERIOD_W-1:0] cmd_min_period;
  logic [PERIOD_W-1:0] cmd_accel;
  logic                busy;
  logic                done;
  logic [POS_W-1:0]    position;
  logic [POS_W-1:0]    steps_remaining;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_start_period, cmd_min_period, cmd_accel,
    input  cmd_ready, busy, done, position, steps_remaining
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_start_period, cmd_min_period, cmd_accel,
    output cmd_ready, busy, done, position, steps_remaining
  );
endinterface

// File: rtl/stepper_ramp_calc.sv
// Combinational next step period / ramp counter for a linear-period trapezoid.
//   period, ramp_cnt  : current values
//   rem               : steps remaining after the step being issued
//   start/min/accel   : ramp settings of the move
//   period_nxt_c      : next period, floored at 2*STEP_HIGH_CYCLES
//   ramp_cnt_nxt_c    : next ramp counter
module stepper_ramp_calc #(
  parameter int unsigned POS_W            = stepper_pkg::POS_W_DEF,
  parameter int unsigned PERIOD_W         = stepper_pkg::PERIOD_W_DEF,
  parameter int unsigned STEP_HIGH_CYCLES = 100
) (
  input  logic [PERIOD_W-1:0] period,
  input  logic [POS_W-1:0]    ramp_cnt,
  input  logic [POS_W-1:0]    rem,
  input  logic [PERIOD_W-1:0] start_period,
  input  logic [PERIOD_W-1:0] min_period,
  input  logic [PERIOD_W-1:0] accel,
  output logic [PERIOD_W-1:0] period_nxt_c,
  output logic [POS_W-1:0]    ramp_cnt_nxt_c
);
  localparam int unsigned EXT_W = PERIOD_W + 1;
  localparam logic [EXT_W-1:0] PERIOD_FLOOR = EXT_W'(2 * STEP_HIGH_CYCLES);

  logic [EXT_W-1:0] per_e, start_e, min_e, accel_e, eff_min_e, sum_e, raw_e;

  // One extra bit keeps period+accel and eff_min+accel from wrapping.
  always_comb begin
    per_e          = {1'b0, period};
    start_e        = {1'b0, start_period};
    min_e          = {1'b0, min_period};
    accel_e        = {1'b0, accel};
    eff_min_e      = (min_e > start_e) ? start_e : min_e;
    sum_e          = per_e + accel_e;
    raw_e          = per_e;
    ramp_cnt_nxt_c = ramp_cnt;

    if (rem <= ramp_cnt) begin
      // decelerate back towards the start period
      raw_e          = (sum_e > start_e) ? start_e : sum_e;
      ramp_cnt_nxt_c = (ramp_cnt == '0) ? '0 : ramp_cnt - POS_W'(1);
    end else if (per_e > eff_min_e) begin
      // accelerate towards the cruise period
      raw_e          = (per_e < eff_min_e + accel_e) ? eff_min_e : per_e - accel_e;
      ramp_cnt_nxt_c = ramp_cnt + POS_W'(1);
    end

    period_nxt_c = (raw_e < PERIOD_FLOOR) ? PERIOD_W'(PERIOD_FLOOR) : PERIOD_W'(raw_e);
  end
endmodule

// File: rtl/stepper_motion_sequencer.sv
// Turns one move command into a STEP/DIR pulse train with a trapezoidal ramp
// and tracks absolute position.
//   ACLK, ARESET : clock, async active-high reset
//   cmd_if       : command handshake and status (slave modport)
//   abort        : level, ends the move early (never truncates a pulse)
//   step_out     : STEP pin
//   dir_out      : DIR pin
module stepper_motion_sequencer #(
  parameter int unsigned POS_W            = stepper_pkg::POS_W_DEF,
  parameter int unsigned PERIOD_W         = stepper_pkg::PERIOD_W_DEF,
  parameter int unsigned STEP_HIGH_CYCLES = 100,
  parameter int unsigned DIR_SETUP_CYCLES = 50
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  stepper_motion_sequencer_if.slave  cmd_if,
  input  logic                       abort,
  output logic                       step_out,
  output logic                       dir_out
);
  import stepper_pkg::*;

  localparam int unsigned EXT_W = PERIOD_W + 1;
  localparam logic [EXT_W-1:0] PERIOD_FLOOR = EXT_W'(2 * STEP_HIGH_CYCLES);

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] tmr_q, tmr_d;
  logic [PERIOD_W-1:0] low_q, low_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] start_q, start_d;
  logic [PERIOD_W-1:0] min_q, min_d;
  logic [PERIOD_W-1:0] accel_q, accel_d;
  logic [POS_W-1:0]    ramp_q, ramp_d;
  logic [POS_W-1:0]    rem_q, rem_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_q, dir_d;
  logic                step_q, step_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                abort_pend_q, abort_pend_d;

  logic                enter_step;
  logic [POS_W-1:0]    rem_dec;
  logic [PERIOD_W-1:0] ramp_period_c;
  logic [POS_W-1:0]    ramp_cnt_c;
  logic [PERIOD_W-1:0] accept_period;

  assign rem_dec       = rem_q - POS_W'(1);
  assign accept_period = ({1'b0, cmd_if.cmd_start_period} < PERIOD_FLOOR) ?
                         PERIOD_W'(PERIOD_FLOOR) : cmd_if.cmd_start_period;

  stepper_ramp_calc #(
    .POS_W            (POS_W),
    .PERIOD_W         (PERIOD_W),
    .STEP_HIGH_CYCLES (STEP_HIGH_CYCLES)
  ) u_ramp (
    .period         (period_q),
    .ramp_cnt       (ramp_q),
    .rem            (rem_dec),
    .start_period   (start_q),
    .min_period     (min_q),
    .accel          (accel_q),
    .period_nxt_c   (ramp_period_c),
    .ramp_cnt_nxt_c (ramp_cnt_c)
  );

  // State and datapath registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      low_q        <= '0;
      period_q     <= '0;
      start_q      <= '0;
      min_q        <= '0;
      accel_q      <= '0;
      ramp_q       <= '0;
      rem_q        <= '0;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      low_q        <= low_d;
      period_q     <= period_d;
      start_q      <= start_d;
      min_q        <= min_d;
      accel_q      <= accel_d;
      ramp_q       <= ramp_d;
      rem_q        <= rem_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Next state, timers, ramp and position
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    low_d        = low_q;
    period_d     = period_q;
    start_d      = start_q;
    min_d        = min_q;
    accel_d      = accel_q;
    ramp_d       = ramp_q;
    rem_d        = rem_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    abort_pend_d = abort_pend_q;
    enter_step   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_if.cmd_valid) begin
          start_d  = cmd_if.cmd_start_period;
          min_d    = cmd_if.cmd_min_period;
          accel_d  = cmd_if.cmd_accel;
          rem_d    = cmd_if.cmd_steps;
          ramp_d   = '0;
          period_d = accept_period;
          if (cmd_if.cmd_steps == '0) begin
            state_d = DONE;
          end else begin
            state_d = DIR_SETUP;
            dir_d   = cmd_if.cmd_dir;
            tmr_d   = PERIOD_W'(DIR_SETUP_CYCLES - 1);
          end
        end
      end
      DIR_SETUP: begin
        if (abort)                 state_d    = DONE;
        else if (tmr_q == '0)      enter_step = 1'b1;
        else                       tmr_d      = tmr_q - PERIOD_W'(1);
      end
      STEP_HIGH: begin
        // an abort seen during the high phase takes effect once it completes
        if (abort) abort_pend_d = 1'b1;
        if (tmr_q == '0) begin
          if (rem_q == '0 || abort || abort_pend_q) begin
            state_d = DONE;
          end else begin
            state_d = STEP_LOW;
            tmr_d   = low_q;
          end
        end else begin
          tmr_d = tmr_q - PERIOD_W'(1);
        end
      end
      STEP_LOW: begin
        if (abort)                 state_d    = DONE;
        else if (tmr_q == '0)      enter_step = 1'b1;
        else                       tmr_d      = tmr_q - PERIOD_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Rising edge of a step: the interval just starting uses the pre-update period.
    if (enter_step) begin
      state_d  = STEP_HIGH;
      tmr_d    = PERIOD_W'(STEP_HIGH_CYCLES - 1);
      low_d    = period_q - PERIOD_W'(STEP_HIGH_CYCLES) - PERIOD_W'(1);
      rem_d    = rem_dec;
      pos_d    = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      period_d = ramp_period_c;
      ramp_d   = ramp_cnt_c;
    end

    if (state_d != STEP_HIGH) abort_pend_d = 1'b0;

    step_d = (state_d == STEP_HIGH);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign step_out               = step_q;
  assign dir_out                = dir_q;
  assign cmd_if.cmd_ready       = (state_q == IDLE);
  assign cmd_if.busy            = busy_q;
  assign cmd_if.done            = done_q;
  assign cmd_if.position        = pos_q;
  assign cmd_if.steps_remaining = rem_q;

endmodule

// File: tb/tb_stepper_motion_sequencer.sv
// Directed bench for stepper_motion_sequencer with STEP_HIGH_CYCLES=4,
// DIR_SETUP_CYCLES=3. A negedge monitor logs step rises, pulse widths, done
// and busy so each scenario task can compare timing against hand values.
module tb_stepper_motion_sequencer;
  import stepper_pkg::*;

  logic ACLK;
  logic ARESET;
  logic abort;
  logic step_out;
  logic dir_out;

  stepper_motion_sequencer_if #(.POS_W(32), .PERIOD_W(24)) bus();

  stepper_motion_sequencer #(
    .POS_W            (32),
    .PERIOD_W         (24),
    .STEP_HIGH_CYCLES (4),
    .DIR_SETUP_CYCLES (3)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .cmd_if   (bus),
    .abort    (abort),
    .step_out (step_out),
    .dir_out  (dir_out)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  int   rise_q[$];
  int   high_q[$];
  int   last_rise   = 0;
  int   done_cnt    = 0;
  int   done_cyc    = -1;
  int   busy_cnt    = 0;
  int   dir_chg_cyc = -1;
  logic prev_step   = 1'b0;
  logic prev_dir    = 1'b0;

  always @(negedge ACLK) begin
    if (step_out === 1'b1 && prev_step !== 1'b1) begin
      rise_q.push_back(cyc);
      last_rise = cyc;
    end
    if (step_out === 1'b0 && prev_step === 1'b1) high_q.push_back(cyc - last_rise);
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.busy === 1'b1) busy_cnt++;
    if (dir_out !== prev_dir) dir_chg_cyc = cyc;
    prev_step = step_out;
    prev_dir  = dir_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    rise_q.delete();
    high_q.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    busy_cnt    = 0;
    dir_chg_cyc = -1;
  endtask

  task automatic issue(input cmd_t c, output int acc);
    @(negedge ACLK);
    bus.cmd_steps        = c.steps;
    bus.cmd_dir          = c.dir;
    bus.cmd_start_period = c.start_period;
    bus.cmd_min_period   = c.min_period;
    bus.cmd_accel        = c.accel;
    bus.cmd_valid        = 1'b1;
    @(posedge ACLK);
    #1;
    acc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge ACLK);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    clear_mon();
    repeat (3) @(negedge ACLK);
    n_checks++; if (step_out !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b expected 0", step_out); end
    n_checks++; if (dir_out !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %b expected 0", dir_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.position !== 32'd0) begin n_fail++; $display("FAIL reset_position: got %0d expected 0", bus.position); end
    n_checks++; if (bus.steps_remaining !== 32'd0) begin n_fail++; $display("FAIL reset_remaining: got %0d expected 0", bus.steps_remaining); end
    ARESET = 1'b0;
    @(negedge ACLK);
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready); end
    // abort in IDLE does nothing
    abort = 1'b1;
    repeat (4) @(negedge ACLK);
    abort = 1'b0;
    #1;
    n_checks++; if (busy_cnt != 0 || done_cnt != 0) begin n_fail++; $display("FAIL idle_abort: got busy_cnt %0d done_cnt %0d expected 0 0", busy_cnt, done_cnt); end
  endtask

  task automatic test_ramp_move();
    cmd_t c;
    int   acc;
    bit   ok;
    int   exp_iv[4] = '{20, 15, 10, 15};
    clear_mon();
    c = '{steps: 32'd5, dir: 1'b1, start_period: 24'd20, min_period: 24'd10, accel: 24'd5};
    issue(c, acc);
    wait_done(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ramp_done_timeout: got no done expected done"); end
    n_checks++; if (rise_q.size() != 5) begin n_fail++; $display("FAIL ramp_pulses: got %0d expected 5", rise_q.size()); end
    n_checks++; if (dir_chg_cyc != acc) begin n_fail++; $display("FAIL ramp_dir_change: got cycle %0d expected %0d", dir_chg_cyc, acc); end
    if (rise_q.size() == 5) begin
      n_checks++; if (rise_q[0] - acc != 3) begin n_fail++; $display("FAIL ramp_first_rise: got %0d expected 3", rise_q[0] - acc); end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rise_q[i+1] - rise_q[i] != exp_iv[i]) begin
          n_fail++; $display("FAIL ramp_interval%0d: got %0d expected %0d", i, rise_q[i+1] - rise_q[i], exp_iv[i]);
        end
      end
      n_checks++; if (done_cyc - rise_q[4] != 4) begin n_fail++; $display("FAIL ramp_done_latency: got %0d expected 4", done_cyc - rise_q[4]); end
    end
    n_checks++; if (high_q.size() != 5) begin n_fail++; $display("FAIL ramp_high_count: got %0d expected 5", high_q.size()); end
    foreach (high_q[i]) begin
      n_checks++; if (high_q[i] != 4) begin n_fail++; $display("FAIL ramp_high%0d: got %0d expected 4", i, high_q[i]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ramp_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (busy_cnt != 68) begin n_fail++; $display("FAIL ramp_busy_cycles: got %0d expected 68", busy_cnt); end
    n_checks++; if (bus.position !== 32'd5) begin n_fail++; $display("FAIL ramp_position: got %0d expected 5", $signed(bus.position)); end
    n_checks++; if (bus.steps_remaining !== 32'd0) begin n_fail++; $display("FAIL ramp_remaining: got %0d expected 0", bus.steps_remaining); end
    n_checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ramp_idle: got busy %b ready %b expected 0 1", bus.busy, bus.cmd_ready); end
  endtask

  task automatic test_cruise_negative();
    cmd_t c;
    int   acc;
    bit   ok;
    clear_mon();
    c = '{steps: 32'd3, dir: 1'b0, start_period: 24'd12, min_period: 24'd12, accel: 24'd0};
    issue(c, acc);
    wait_done(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cruise_done_timeout: got no done expected done"); end
    n_checks++; if (rise_q.size() != 3) begin n_fail++; $display("FAIL cruise_pulses: got %0d expected 3", rise_q.size()); end
    if (rise_q.size() == 3) begin
      n_checks++; if (rise_q[0] - dir_chg_cyc != 3) begin n_fail++; $display("FAIL cruise_dir_setup: got %0d expected 3", rise_q[0] - dir_chg_cyc); end
      n_checks++; if (rise_q[1] - rise_q[0] != 12) begin n_fail++; $display("FAIL cruise_interval0: got %0d expected 12", rise_q[1] - rise_q[0]); end
      n_checks++; if (rise_q[2] - rise_q[1] != 12) begin n_fail++; $display("FAIL cruise_interval1: got %0d expected 12", rise_q[2] - rise_q[1]); end
    end
    n_checks++; if (dir_out !== 1'b0) begin n_fail++; $display("FAIL cruise_dir: got %b expected 0", dir_out); end
    n_checks++; if (bus.position !== 32'd2) begin n_fail++; $display("FAIL cruise_position: got %0d expected 2", $signed(bus.position)); end
  endtask

  task automatic test_zero_steps();
    cmd_t c;
    int   acc;
    bit   ok;
    clear_mon();
    c = '{steps: 32'd0, dir: 1'b1, start_period: 24'd20, min_period: 24'd10, accel: 24'd5};
    issue(c, acc);
    wait_done(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_done_timeout: got no done expected done"); end
    n_checks++; if (rise_q.size() != 0) begin n_fail++; $display("FAIL zero_pulses: got %0d expected 0", rise_q.size()); end
    n_checks++; if (done_cyc != acc) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected %0d", done_cyc, acc); end
    n_checks++; if (busy_cnt != 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 1", busy_cnt); end
    n_checks++; if (dir_out !== 1'b0) begin n_fail++; $display("FAIL zero_dir_unchanged: got %b expected 0", dir_out); end
    n_checks++; if (bus.position !== 32'd2) begin n_fail++; $display("FAIL zero_position: got %0d expected 2", $signed(bus.position)); end
  endtask

  task automatic test_abort();
    cmd_t c;
    int   acc;
    bit   ok;
    clear_mon();
    c = '{steps: 32'd100, dir: 1'b1, start_period: 24'd20, min_period: 24'd10, accel: 24'd5};
    issue(c, acc);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      #1;
      if (rise_q.size() >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_third_rise_timeout: got %0d rises expected 3", rise_q.size()); end
    repeat (2) @(posedge ACLK);
    #1;
    abort = 1'b1;
    wait_done(50, ok);
    abort = 1'b0;
    repeat (30) @(negedge ACLK);
    #1;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_done_timeout: got no done expected done"); end
    n_checks++; if (rise_q.size() != 3) begin n_fail++; $display("FAIL abort_pulses: got %0d expected 3", rise_q.size()); end
    if (rise_q.size() == 3) begin
      n_checks++; if (rise_q[2] - rise_q[1] != 15) begin n_fail++; $display("FAIL abort_interval1: got %0d expected 15", rise_q[2] - rise_q[1]); end
      n_checks++; if (done_cyc - rise_q[2] != 4) begin n_fail++; $display("FAIL abort_done_latency: got %0d expected 4", done_cyc - rise_q[2]); end
    end
    n_checks++; if (high_q.size() != 3 || high_q[high_q.size()-1] != 4) begin n_fail++; $display("FAIL abort_last_high: got count %0d expected 3 pulses of 4", high_q.size()); end
    n_checks++; if (bus.steps_remaining !== 32'd97) begin n_fail++; $display("FAIL abort_remaining: got %0d expected 97", bus.steps_remaining); end
    n_checks++; if (bus.position !== 32'd5) begin n_fail++; $display("FAIL abort_position: got %0d expected 5", $signed(bus.position)); end

    // abort during direction setup ends the move on the next edge
    clear_mon();
    c = '{steps: 32'd10, dir: 1'b1, start_period: 24'd20, min_period: 24'd10, accel: 24'd5};
    issue(c, acc);
    abort = 1'b1;
    wait_done(20, ok);
    abort = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_setup_timeout: got no done expected done"); end
    n_checks++; if (done_cyc - acc != 1) begin n_fail++; $display("FAIL abort_setup_latency: got %0d expected 1", done_cyc - acc); end
    n_checks++; if (rise_q.size() != 0) begin n_fail++; $display("FAIL abort_setup_pulses: got %0d expected 0", rise_q.size()); end
    n_checks++; if (bus.steps_remaining !== 32'd10) begin n_fail++; $display("FAIL abort_setup_remaining: got %0d expected 10", bus.steps_remaining); end
  endtask

  task automatic test_clamp();
    cmd_t c;
    int   acc;
    bit   ok;
    clear_mon();
    c = '{steps: 32'd3, dir: 1'b1, start_period: 24'd5, min_period: 24'd5, accel: 24'd1};
    issue(c, acc);
    wait_done(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clamp_done_timeout: got no done expected done"); end
    n_checks++; if (rise_q.size() != 3) begin n_fail++; $display("FAIL clamp_pulses: got %0d expected 3", rise_q.size()); end
    if (rise_q.size() == 3) begin
      n_checks++; if (rise_q[1] - rise_q[0] != 8) begin n_fail++; $display("FAIL clamp_interval0: got %0d expected 8", rise_q[1] - rise_q[0]); end
      n_checks++; if (rise_q[2] - rise_q[1] != 8) begin n_fail++; $display("FAIL clamp_interval1: got %0d expected 8", rise_q[2] - rise_q[1]); end
    end
    n_checks++; if (bus.position !== 32'd8) begin n_fail++; $display("FAIL clamp_position: got %0d expected 8", $signed(bus.position)); end
  endtask

  task automatic test_back_to_back();
    int acc;
    int ready_hi = 0;
    bit ok = 1'b0;
    clear_mon();
    @(negedge ACLK);
    bus.cmd_steps        = 32'd2;
    bus.cmd_dir          = 1'b1;
    bus.cmd_start_period = 24'd8;
    bus.cmd_min_period   = 24'd8;
    bus.cmd_accel        = 24'd0;
    bus.cmd_valid        = 1'b1;
    @(posedge ACLK);
    #1;
    acc = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (bus.cmd_ready !== 1'b0) ready_hi++;
      if (bus.done === 1'b1) begin
        bus.cmd_valid = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge ACLK);
    #1;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_done_timeout: got no done expected done"); end
    n_checks++; if (ready_hi != 0) begin n_fail++; $display("FAIL hold_ready_busy: got %0d ready cycles expected 0", ready_hi); end
    n_checks++; if (rise_q.size() != 2) begin n_fail++; $display("FAIL hold_pulses: got %0d expected 2", rise_q.size()); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL hold_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (done_cyc - acc != 15) begin n_fail++; $display("FAIL hold_move_length: got %0d expected 15", done_cyc - acc); end
    n_checks++; if (bus.position !== 32'd10) begin n_fail++; $display("FAIL hold_position: got %0d expected 10", $signed(bus.position)); end
  endtask

  task automatic test_async_reset();
    cmd_t c;
    int   acc;
    bit   ok = 1'b0;
    clear_mon();
    c = '{steps: 32'd50, dir: 1'b1, start_period: 24'd20, min_period: 24'd10, accel: 24'd5};
    issue(c, acc);
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      #1;
      if (step_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL areset_rise_timeout: got no step expected step"); end
    #2;
    ARESET = 1'b1;
    #1;
    n_checks++; if (step_out !== 1'b0) begin n_fail++; $display("FAIL areset_step: got %b expected 0", step_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.position !== 32'd0) begin n_fail++; $display("FAIL areset_position: got %0d expected 0", $signed(bus.position)); end
    n_checks++; if (bus.steps_remaining !== 32'd0) begin n_fail++; $display("FAIL areset_remaining: got %0d expected 0", bus.steps_remaining); end
    n_checks++; if (dir_out !== 1'b0) begin n_fail++; $display("FAIL areset_dir: got %b expected 0", dir_out); end
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b expected 1", bus.cmd_ready); end
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    #1;
    n_checks++; if (bus.busy !== 1'b0 || step_out !== 1'b0) begin n_fail++; $display("FAIL areset_after: got busy %b step %b expected 0 0", bus.busy, step_out); end

    // one negative step from zero wraps to all ones
    clear_mon();
    c = '{steps: 32'd1, dir: 1'b0, start_period: 24'd8, min_period: 24'd8, accel: 24'd0};
    issue(c, acc);
    wait_done(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL post_reset_timeout: got no done expected done"); end
    n_checks++; if (rise_q.size() != 1) begin n_fail++; $display("FAIL post_reset_pulses: got %0d expected 1", rise_q.size()); end
    n_checks++; if (done_cyc - acc != 7) begin n_fail++; $display("FAIL post_reset_length: got %0d expected 7", done_cyc - acc); end
    n_checks++; if (bus.position !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL post_reset_position: got %0d expected -1", $signed(bus.position)); end
  endtask

  initial begin
    ARESET               = 1'b1;
    abort                = 1'b0;
    bus.cmd_valid        = 1'b0;
    bus.cmd_steps        = '0;
    bus.cmd_dir          = 1'b0;
    bus.cmd_start_period = '0;
    bus.cmd_min_period   = '0;
    bus.cmd_accel        = '0;

    test_reset();
    test_ramp_move();
    test_cruise_negative();
    test_zero_steps();
    test_abort();
    test_clamp();
    test_back_to_back();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
